// File: rtl/sdf_delay_line_if.sv
// sdf_delay_line_if: stream bundle for the SDF delay line (control, sample in, delayed sample out, fill status)
interface sdf_delay_line_if #(
  parameter int WIDTH    = 19,
  parameter int LOG2_MAX = 4
);
  logic                en;
  logic                flush;
  logic [LOG2_MAX:0]   len_sel;
  logic [WIDTH-1:0]    in_r;
  logic [WIDTH-1:0]    in_i;
  logic [WIDTH-1:0]    out_r;
  logic [WIDTH-1:0]    out_i;
  logic                out_valid;
  logic [LOG2_MAX:0]   fill;
  modport master (output en, flush, len_sel, in_r, in_i, input out_r, out_i, out_valid, fill);
  modport slave  (input en, flush, len_sel, in_r, in_i, output out_r, out_i, out_valid, fill);
endinterface

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: complex delay line of runtime depth 2^len_sel with stall, flush and fill tracking (ports: clk, rst, bus slave)
module sdf_delay_line #(
  parameter int WIDTH    = 19,
  parameter int LOG2_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  sdf_delay_line_if.slave   bus
);
  localparam int MAX_DEPTH = 1 << LOG2_MAX;
  localparam int LW        = LOG2_MAX + 1;
  logic [WIDTH-1:0]    st_r [MAX_DEPTH];
  logic [WIDTH-1:0]    st_i [MAX_DEPTH];
  logic [LW-1:0]       cur_len;
  logic [LW-1:0]       len_c;
  logic [LW-1:0]       fill_q;
  logic [LW-1:0]       depth;
  logic [LOG2_MAX-1:0] tap;
  // out-of-range selects behave as the maximum depth, including for change detection
  assign len_c = (bus.len_sel > LW'(LOG2_MAX)) ? LW'(LOG2_MAX) : bus.len_sel;
  assign depth = LW'(1) << cur_len;
  assign tap   = LOG2_MAX'(depth - LW'(1));
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      for (int k = 0; k < MAX_DEPTH; k++) begin
        st_r[k] <= '0;
        st_i[k] <= '0;
      end
      fill_q  <= '0;
      cur_len <= rst ? LW'(LOG2_MAX) : len_c;
    end else begin
      if (bus.en) begin
        st_r[0] <= bus.in_r;
        st_i[0] <= bus.in_i;
        for (int k = 1; k < MAX_DEPTH; k++) begin
          st_r[k] <= st_r[k-1];
          st_i[k] <= st_i[k-1];
        end
      end
      cur_len <= len_c;
      fill_q  <= (len_c != cur_len) ? '0 : (bus.en && fill_q < depth) ? fill_q + LW'(1) : fill_q;
    end
  end
  assign bus.out_r     = st_r[tap];
  assign bus.out_i     = st_i[tap];
  assign bus.fill      = fill_q;
  assign bus.out_valid = (fill_q == depth);
endmodule

// File: tb/tb_sdf_delay_line.sv
// tb_sdf_delay_line: directed and table-driven checks of sdf_delay_line
module tb_sdf_delay_line;
  logic clk = 0;
  logic rst = 1;
  int   total = 0;
  int   passed = 0;
  int   m;
  sdf_delay_line_if #(.WIDTH(19), .LOG2_MAX(4)) bus ();
  sdf_delay_line #(.WIDTH(19), .LOG2_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic     en;
    logic     fl;
    int       ls;
    int       v;
    int       er;
    int       ef;
    logic     ev;
  } vec_t;
  vec_t tbl [13];
  function automatic int neg(input int v);
    logic [18:0] t;
    t = 19'(-v);
    return int'({13'b0, t});
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  task automatic drive(input logic e, input logic f, input int ls, input int v);
    bus.en      = e;
    bus.flush   = f;
    bus.len_sel = 5'(ls);
    bus.in_r    = 19'(v);
    bus.in_i    = 19'(-v);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_out(input string n, input int er, input int ef, input logic ev);
    chk({n, " out_r"}, int'(bus.out_r), er);
    chk({n, " out_i"}, int'(bus.out_i), neg(er));
    chk({n, " fill"}, int'(bus.fill), ef);
    chk({n, " valid"}, int'(bus.out_valid), int'(ev));
  endtask
  initial begin
    tbl[0]  = '{1, 1, 0, 0,  0,  0, 0};
    tbl[1]  = '{1, 0, 0, 11, 11, 1, 1};
    tbl[2]  = '{1, 0, 0, 12, 12, 1, 1};
    tbl[3]  = '{0, 0, 0, 99, 12, 1, 1};
    tbl[4]  = '{1, 0, 0, 13, 13, 1, 1};
    tbl[5]  = '{1, 0, 7, 14, 0,  0, 0};
    tbl[6]  = '{1, 0, 7, 15, 0,  1, 0};
    tbl[7]  = '{1, 0, 4, 16, 0,  2, 0};
    tbl[8]  = '{1, 0, 1, 17, 16, 0, 0};
    tbl[9]  = '{1, 0, 1, 18, 17, 1, 0};
    tbl[10] = '{1, 0, 1, 19, 18, 2, 1};
    tbl[11] = '{1, 0, 1, 20, 19, 2, 1};
    tbl[12] = '{0, 0, 2, 21, 17, 0, 0};
    drive(1, 0, 4, 0);
    for (int c = 0; c < 2; c++) begin
      bus.in_r = 19'($urandom);
      bus.in_i = 19'($urandom);
      tick();
    end
    check_out("reset", 0, 0, 0);
    chk("reset cur_len", int'(dut.cur_len), 4);
    rst = 0;
    for (int n = 1; n <= 20; n++) begin
      drive(1, 0, 4, n);
      tick();
      check_out($sformatf("fill16 n=%0d", n), n >= 16 ? n - 15 : 0, n >= 16 ? 16 : n, n >= 16);
    end
    drive(1, 1, 4, 777);
    tick();
    check_out("flush", 0, 0, 0);
    m = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c % 2 == 1) begin
        m++;
        drive(1, 0, 4, m);
      end else drive(0, 0, 4, 500 + c);
      tick();
      check_out($sformatf("stall c=%0d", c), m >= 16 ? m - 15 : 0, m >= 16 ? 16 : m, m >= 16);
    end
    m++;
    drive(1, 0, 3, m);
    tick();
    check_out("len 4->3", m - 7, 0, 0);
    for (int j = 1; j <= 8; j++) begin
      m++;
      drive(1, 0, 3, m);
      tick();
      check_out($sformatf("refill8 j=%0d", j), m - 7, j, j == 8);
    end
    m++;
    drive(1, 0, 4, m);
    tick();
    check_out("len 3->4", m - 15, 0, 0);
    for (int j = 1; j <= 10; j++) begin
      m++;
      drive(1, 0, 4, m);
      tick();
      check_out($sformatf("pre-flush j=%0d", j), m - 15, j, 0);
    end
    drive(1, 1, 4, 999);
    tick();
    check_out("flush+en", 0, 0, 0);
    drive(1, 0, 4, 5);
    tick();
    check_out("post-flush shift", 0, 1, 0);
    for (int r = 0; r < 13; r++) begin
      drive(tbl[r].en, tbl[r].fl, tbl[r].ls, tbl[r].v);
      tick();
      check_out($sformatf("tbl row %0d", r), tbl[r].er, tbl[r].ef, tbl[r].ev);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
